// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the CPU core, the access controller and the byte-wide memory bus.
// master: the CPU/memory environment side; slave: the access controller.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_BUS_WIDTH = 48
);
  logic                      req_valid;
  logic                      req_we;
  logic [1:0]                req_size;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [31:0]               req_wdata;
  logic                      cpu_enable;
  logic [DATA_BUS_WIDTH-1:0] cpu_data_in;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [7:0]                mem_wdata;
  logic [7:0]                mem_rdata;
  logic                      mem_ack;
  logic                      err_clr;
  logic                      err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_ack, err_clr,
    input  cpu_enable, cpu_data_in, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_ack, err_clr,
    output cpu_enable, cpu_data_in, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Serialises a CPU memory request into byte transactions and assembles read data little-endian.
// Optional MEM_ACCESS_CTRL_ALIGN_CHECK_EN rejects misaligned 16/32/48-bit accesses without bus cycles.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_BUS_WIDTH = 48,
  parameter int ACK_TIMEOUT    = 255
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam int NUM_LANES = DATA_BUS_WIDTH / 8;
  localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                      we_reg;
  logic [2:0]                count_reg;
  logic [2:0]                idx_reg;
  logic [23:0]               wdata_reg;
  logic [TMO_W-1:0]          tmo_reg;
  logic [DATA_BUS_WIDTH-1:0] data_reg;
  logic [DATA_BUS_WIDTH-1:0] data_next;
  logic                      err_reg;
  logic                      mem_req_reg;
  logic                      mem_we_reg;
  logic [ADDR_WIDTH-1:0]     mem_addr_reg;
  logic [7:0]                mem_wdata_reg;

  logic [2:0] req_count;
  logic       misaligned;
  logic       reject_req;
  logic       accept;
  logic       reject;
  logic       ack_byte;
  logic       last_byte;
  logic       abort;
  logic       tmo_inc;
  logic       err_set;

  always_comb begin
    case (bus.req_size)
      2'b00:   req_count = 3'd1;
      2'b01:   req_count = 3'd2;
      2'b10:   req_count = 3'd4;
      default: req_count = 3'd6;
    endcase
  end

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
  always_comb begin
    case (bus.req_size)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = bus.req_addr[0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // 48-bit writes do not exist; such requests complete immediately with err.
  assign reject_req = (bus.req_we && (bus.req_size == 2'b11)) || misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    ack_byte   = 1'b0;
    last_byte  = 1'b0;
    abort      = 1'b0;
    tmo_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (reject_req) begin
            reject     = 1'b1;
            state_next = DONE;
          end else begin
            accept     = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          ack_byte = 1'b1;
          if (idx_reg == (count_reg - 3'd1)) begin
            last_byte  = 1'b1;
            state_next = DONE;
          end
        end else if (tmo_reg == TMO_LAST) begin
          abort      = 1'b1;
          state_next = DONE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign err_set = reject | abort;

  // Each read byte lands in its own lane; lanes are cleared when a new request is taken.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      if (gi < 6) begin : g_used
        assign data_next[gi*8 +: 8] =
          (accept || reject) ? 8'h00 :
          (ack_byte && !we_reg && (idx_reg == 3'(gi))) ? bus.mem_rdata :
          data_reg[gi*8 +: 8];
      end else begin : g_unused
        assign data_next[gi*8 +: 8] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg        <= 1'b0;
      count_reg     <= 3'd0;
      idx_reg       <= 3'd0;
      wdata_reg     <= 24'h0;
      tmo_reg       <= '0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'h00;
    end else begin
      data_reg <= data_next;
      if (err_set) begin
        err_reg <= 1'b1;
      end else if (bus.err_clr) begin
        err_reg <= 1'b0;
      end
      if (accept || reject) begin
        we_reg    <= bus.req_we;
        count_reg <= req_count;
        idx_reg   <= 3'd0;
        tmo_reg   <= '0;
        wdata_reg <= bus.req_wdata[31:8];
      end
      if (accept) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= bus.req_we;
        mem_addr_reg  <= bus.req_addr;
        mem_wdata_reg <= bus.req_wdata[7:0];
      end
      if (ack_byte) begin
        idx_reg <= idx_reg + 3'd1;
        tmo_reg <= '0;
        if (last_byte) begin
          mem_req_reg <= 1'b0;
          mem_we_reg  <= 1'b0;
        end else begin
          mem_addr_reg  <= mem_addr_reg + ADDR_WIDTH'(1);
          mem_wdata_reg <= wdata_reg[7:0];
          wdata_reg     <= {8'h00, wdata_reg[23:8]};
        end
      end
      if (tmo_inc) begin
        tmo_reg <= tmo_reg + TMO_W'(1);
      end
      if (abort) begin
        mem_req_reg <= 1'b0;
        mem_we_reg  <= 1'b0;
      end
    end
  end

  assign bus.cpu_enable  = (state_reg == DONE) || ((state_reg == IDLE) && !bus.req_valid);
  assign bus.cpu_data_in = data_reg;
  assign bus.err         = err_reg;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
endmodule
